// File: rtl/display_pkg.sv
// Shared constants and state encoding for the multiplexed display scanner.
package display_pkg;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam int NUM_DIGITS = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_HOLD = 1'b1
    } scan_state_t;
endpackage

// File: rtl/lz_blank_mask.sv
// Leading-zero mask: bit i set when digits 7..i are all zero; digit 0 never masked.
module lz_blank_mask
    import display_pkg::*;
(
    input  logic [4*NUM_DIGITS-1:0] image,
    output logic [NUM_DIGITS-1:0]   mask
);

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (image[4*i +: 4] == 4'h0);
            mask[i] = zero_above && (i != 0);
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Double-buffered 8-digit scan controller feeding the draw stage's number/index latches.
//   state  | meaning
//   S_LOAD | slot outputs just loaded, strobes high (one cycle)
//   S_HOLD | down-counter running out the remainder of the slot
module display_scanner
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [3:0]       wr_digit,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic             blank_lz,
    output logic [3:0]       value,
    output logic [IDX_W-1:0] index,
    output logic             load_number,
    output logic             load_index,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    scan_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [4*NUM_DIGITS-1:0] shadow_img, shadow_next;
    logic [4*NUM_DIGITS-1:0] active_img, active_next;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [IDX_W-1:0] index_next;
    logic pending, wr_accept, commit_accept, commit_now, terminal, load_now;
    logic [3:0] slot_code;
    logic slot_blank;

    assign commit_ready  = ~pending;
    assign wr_ready      = commit_ready;
    assign wr_accept     = wr_valid && wr_ready;
    assign commit_accept = commit_valid && commit_ready;
    assign terminal      = (state == S_HOLD) && (cnt == CNT_W'(1));
    assign frame_done    = terminal && (index == IDX_W'(NUM_DIGITS - 1));
    // A commit accepted on the wrap cycle itself is applied at that same edge.
    assign commit_now    = frame_done && (pending || commit_accept);
    assign index_next    = terminal ? index + IDX_W'(1) : index;

    always_comb begin
        shadow_next = shadow_img;
        if (wr_accept) shadow_next[{wr_index, 2'b00} +: 4] = wr_digit;
    end

    assign active_next = commit_now ? shadow_next : active_img;

    // Slot outputs are derived from the image active after this edge, so a commit shows at slot 0.
    lz_blank_mask u_lz_blank_mask (
        .image (active_next),
        .mask  (blank_mask)
    );

    assign slot_code  = active_next[{index_next, 2'b00} +: 4];
    assign slot_blank = blank_lz && blank_mask[index_next];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_now   = 1'b0;
        case (state)
            S_LOAD: begin
                // Out of reset the strobes are low: the first edge primes slot 0 before holding.
                if (load_number) state_next = S_HOLD;
                else load_now = 1'b1;
            end
            S_HOLD: begin
                if (terminal) begin
                    state_next = S_LOAD;
                    cnt_next   = CNT_LOAD;
                    load_now   = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_LOAD;
            cnt         <= CNT_LOAD;
            shadow_img  <= '0;
            active_img  <= '0;
            pending     <= 1'b0;
            index       <= '0;
            value       <= 4'h0;
            load_number <= 1'b0;
            load_index  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            shadow_img  <= shadow_next;
            active_img  <= active_next;
            pending     <= commit_now ? 1'b0 : (pending || commit_accept);
            load_number <= load_now;
            load_index  <= load_now;
            if (load_now) begin
                index <= index_next;
                value <= slot_blank ? CODE_BLANK : slot_code;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: reference model checked every cycle plus image tables.
module tb_display_scanner;
    localparam int DIV = 4;
    localparam int FRAME = 8 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_valid = 1'b0, commit_valid = 1'b0, blank_lz = 1'b0;
    logic [2:0] wr_index = '0;
    logic [3:0] wr_digit = '0;
    logic wr_ready, commit_ready, load_number, load_index, frame_done;
    logic [3:0] value;
    logic [2:0] index;

    always #5 clk = ~clk;

    display_scanner #(.CLK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_index     (wr_index),
        .wr_digit     (wr_digit),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .blank_lz     (blank_lz),
        .value        (value),
        .index        (index),
        .load_number  (load_number),
        .load_index   (load_index),
        .frame_done   (frame_done)
    );

    int total = 0;
    int bad = 0;
    int t = 0;
    logic [3:0] m_sh [8];
    logic [3:0] m_act [8];
    logic m_pend = 1'b0;
    logic m_lz = 1'b0;

    typedef struct {
        logic [31:0] img;
        logic        blz;
        logic [31:0] disp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d)", name, got, exp, t);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0d)", name, t);
    endtask

    function automatic logic [3:0] exp_value(input int slot);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 7; j >= slot; j--) if (m_act[j] != 4'h0) all_zero = 1'b0;
        if (m_lz && slot != 0 && all_zero) return 4'hF;
        return m_act[slot];
    endfunction

    task automatic check_now();
        int slot;
        slot = (t / DIV) % 8;
        chk("index", 32'(index), 32'(slot));
        chk("value", 32'(value), 32'(exp_value(slot)));
        chk("load_number", 32'(load_number), 32'(t % DIV == 0));
        chk("load_index", 32'(load_index), 32'(t % DIV == 0));
        chk("frame_done", 32'(frame_done), 32'(t % FRAME == FRAME - 1));
        chk("commit_ready", 32'(commit_ready), 32'(!m_pend));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    endtask

    task automatic tick();
        logic acc_w, acc_c;
        check_now();
        acc_w = wr_valid && !m_pend;
        acc_c = commit_valid && !m_pend;
        if (acc_w) m_sh[wr_index] = wr_digit;
        if (t % FRAME == FRAME - 1 && (m_pend || acc_c)) begin
            m_act = m_sh;
            m_pend = 1'b0;
        end else if (acc_c) begin
            m_pend = 1'b1;
        end
        if ((t + 1) % DIV == 0) m_lz = blank_lz;
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        commit_valid = 1'b0;
    endtask

    // Called at a negedge with reset asserted.
    task automatic release_reset();
        idle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_sh[i] = 4'h0;
            m_act[i] = 4'h0;
        end
        m_pend = 1'b0;
        m_lz = blank_lz;
        @(posedge clk);
        @(negedge clk);
        t = 0;
    endtask

    task automatic wait_phase(input int phase);
        int n;
        n = 0;
        while (t % FRAME != phase && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (t % FRAME != phase) timeout_fail("wait_phase");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_pend && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (m_pend) timeout_fail("wait_idle");
    endtask

    task automatic capture_frame(output logic [31:0] got);
        got = '0;
        wait_phase(0);
        for (int s = 0; s < 8; s++) begin
            got[4*s +: 4] = value;
            repeat (DIV) tick();
        end
    endtask

    initial begin
        logic [31:0] got;
        int fd_count;

        vecs[0] = '{img: 32'h0000_4321, blz: 1'b0, disp: 32'h0000_4321};
        vecs[1] = '{img: 32'h0000_0502, blz: 1'b1, disp: 32'hFFFF_F502};
        vecs[2] = '{img: 32'h0000_0000, blz: 1'b1, disp: 32'hFFFF_FFF0};
        vecs[3] = '{img: 32'h0000_0000, blz: 1'b0, disp: 32'h0000_0000};
        vecs[4] = '{img: 32'h8765_4321, blz: 1'b1, disp: 32'h8765_4321};
        vecs[5] = '{img: 32'h00A0_0010, blz: 1'b1, disp: 32'hFFA0_0010};
        vecs[6] = '{img: 32'h0F00_0003, blz: 1'b1, disp: 32'hFF00_0003};
        vecs[7] = '{img: 32'h0000_0502, blz: 1'b0, disp: 32'h0000_0502};

        // Reset values while reset is held.
        @(negedge clk);
        chk("reset value", 32'(value), 32'h0);
        chk("reset index", 32'(index), 32'h0);
        chk("reset load_number", 32'(load_number), 32'h0);
        chk("reset load_index", 32'(load_index), 32'h0);
        chk("reset frame_done", 32'(frame_done), 32'h0);
        chk("reset commit_ready", 32'(commit_ready), 32'h1);
        chk("reset wr_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        release_reset();

        // Free-running scan: index/strobe/frame_done checked by the model every cycle.
        fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (frame_done) fd_count++;
            tick();
        end
        chk("frame_done per 2 frames", 32'(fd_count), 32'd2);

        // Image table: write all digits, commit, read back the next full frame.
        foreach (vecs[k]) begin
            wait_idle();
            blank_lz = vecs[k].blz;
            for (int i = 0; i < 8; i++) begin
                wr_valid = 1'b1;
                wr_index = 3'(i);
                wr_digit = vecs[k].img[4*i +: 4];
                tick();
            end
            idle();
            commit_valid = 1'b1;
            tick();
            idle();
            capture_frame(got);
            chk($sformatf("table[%0d] frame", k), got, vecs[k].disp);
        end

        // Write refused while a commit is pending.
        wait_idle();
        wait_phase(5);
        wr_valid = 1'b1; wr_index = 3'd0; wr_digit = 4'd7; commit_valid = 1'b1;
        tick();
        idle();
        chk("pending commit_ready low", 32'(commit_ready), 32'h0);
        wr_valid = 1'b1; wr_index = 3'd0; wr_digit = 4'd9;
        tick();
        idle();
        wait_idle();
        commit_valid = 1'b1;
        tick();
        idle();
        wait_phase(0);
        chk("write while pending ignored", 32'(value), 32'd7);

        // Write and commit together on slot 7's last cycle.
        wait_idle();
        wait_phase(FRAME - 1);
        wr_valid = 1'b1; wr_index = 3'd0; wr_digit = 4'd6; commit_valid = 1'b1;
        tick();
        idle();
        chk("wrap write+commit slot0", 32'(value), 32'd6);
        chk("wrap commit_ready", 32'(commit_ready), 32'h1);

        // Asynchronous reset mid-slot 5 with a commit pending.
        wait_idle();
        wait_phase(2);
        wr_valid = 1'b1; wr_index = 3'd1; wr_digit = 4'd3; commit_valid = 1'b1;
        tick();
        idle();
        wait_phase(5 * DIV + 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset value", 32'(value), 32'h0);
        chk("async reset index", 32'(index), 32'h0);
        chk("async reset load_number", 32'(load_number), 32'h0);
        chk("async reset frame_done", 32'(frame_done), 32'h0);
        chk("async reset commit_ready", 32'(commit_ready), 32'h1);
        @(negedge clk);
        release_reset();
        chk("restart slot0 value", 32'(value), 32'h0);
        repeat (FRAME + 4) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_index = 3'($urandom_range(0, 7));
            wr_digit = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            commit_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
            tick();
        end
        idle();
        repeat (FRAME) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
